// File: rtl/operand_fetch.sv
// operand_fetch: integer register file plus the operand-fetch pipeline register
// that feeds the ALU. Writeback data is forwarded into fresh reads and into
// operands that are held while the ALU stalls.
`ifndef WORD_SIZE_B
`define WORD_SIZE_B 4
`endif

module operand_fetch #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_rs1_addr,
    input  logic [ADDR_W-1:0]         in_rs2_addr,
    input  logic [ADDR_W-1:0]         in_rd_addr,
    input  logic [3:0]                in_control,
    input  logic                      wb_en,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [8*`WORD_SIZE_B-1:0] wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [8*`WORD_SIZE_B-1:0] out_rs1,
    output logic [8*`WORD_SIZE_B-1:0] out_rs2,
    output logic [ADDR_W-1:0]         out_rd_addr,
    output logic [3:0]                out_control
);

    localparam int W = 8 * `WORD_SIZE_B;

    // Architectural registers; entry 0 is never written so it stays zero.
    logic [W-1:0]        r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_we;

    // Output pipeline register and the source addresses it was fetched from.
    logic                r_out_valid;
    logic [W-1:0]        r_rs1;
    logic [W-1:0]        r_rs2;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [3:0]          r_control;
    logic [ADDR_W-1:0]   r_src1;
    logic [ADDR_W-1:0]   r_src2;

    logic                w_accept;
    logic                w_stall;
    logic [W-1:0]        w_rs1_val;
    logic [W-1:0]        w_rs2_val;
    logic                w_hit1;
    logic                w_hit2;

    // Per-register write enables; register 0 is hardwired to discard writes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
            if (gi == 0) begin : g_zero
                assign w_we[gi] = 1'b0;
            end else begin : g_live
                assign w_we[gi] = wb_en && (wb_addr == ADDR_W'(gi));
            end
        end
    endgenerate

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_stall  = r_out_valid && !out_ready;

    // Held operands pick up writeback to their (nonzero) source register.
    assign w_hit1 = wb_en && (r_src1 != '0) && (wb_addr == r_src1);
    assign w_hit2 = wb_en && (r_src2 != '0) && (wb_addr == r_src2);

    // Fresh operand read: zero register, then same-cycle forward, then array.
    always_comb begin
        w_rs1_val = r_regs[in_rs1_addr];
        w_rs2_val = r_regs[in_rs2_addr];
        if (in_rs1_addr == '0) begin
            w_rs1_val = '0;
        end else if (wb_en && (wb_addr == in_rs1_addr)) begin
            w_rs1_val = wb_data;
        end
        if (in_rs2_addr == '0) begin
            w_rs2_val = '0;
        end else if (wb_en && (wb_addr == in_rs2_addr)) begin
            w_rs2_val = wb_data;
        end
    end

    // Register file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= wb_data;
                end
            end
        end
    end

    // Output register: load on accept, refresh on stall, clear valid on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd_addr   <= '0;
            r_control   <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_rs1       <= w_rs1_val;
            r_rs2       <= w_rs2_val;
            r_rd_addr   <= in_rd_addr;
            r_control   <= in_control;
            r_src1      <= in_rs1_addr;
            r_src2      <= in_rs2_addr;
        end else if (w_stall) begin
            if (w_hit1) begin
                r_rs1 <= wb_data;
            end
            if (w_hit2) begin
                r_rs2 <= wb_data;
            end
        end else if (r_out_valid) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_rs1     = r_rs1;
    assign out_rs2     = r_rs2;
    assign out_rd_addr = r_rd_addr;
    assign out_control = r_control;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vectors, a behavioural model checked every
// cycle, and literal expectations at the key points of each scenario.
`ifndef WORD_SIZE_B
`define WORD_SIZE_B 4
`endif

module tb_operand_fetch;

    localparam int W      = 8 * `WORD_SIZE_B;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1_addr = '0;
    logic [ADDR_W-1:0] in_rs2_addr = '0;
    logic [ADDR_W-1:0] in_rd_addr = '0;
    logic [3:0]        in_control = '0;
    logic              wb_en = 1'b0;
    logic [ADDR_W-1:0] wb_addr = '0;
    logic [W-1:0]      wb_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [W-1:0]      out_rs1;
    logic [W-1:0]      out_rs2;
    logic [ADDR_W-1:0] out_rd_addr;
    logic [3:0]        out_control;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    operand_fetch #(.NUM_REGS(NREG), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rd_addr(in_rd_addr), .in_control(in_control),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd_addr(out_rd_addr), .out_control(out_control)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Registers hold "the value after this cycle's writeback"; any read in a
    // cycle sees that value, which captures forwarding without a bypass path.
    logic [W-1:0]      m_regs [NREG];
    logic              m_valid;
    logic [W-1:0]      m_rs1, m_rs2;
    logic [ADDR_W-1:0] m_rd, m_src1, m_src2;
    logic [3:0]        m_ctrl;

    function automatic logic [W-1:0] cur(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_regs[i] <= '0;
            m_valid <= 1'b0;
            m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_ctrl <= '0;
            m_src1 <= '0; m_src2 <= '0;
        end else begin
            if (in_valid && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_rs1 <= cur(in_rs1_addr);
                m_rs2 <= cur(in_rs2_addr);
                m_rd <= in_rd_addr;
                m_ctrl <= in_control;
                m_src1 <= in_rs1_addr;
                m_src2 <= in_rs2_addr;
            end else if (m_valid && !out_ready) begin
                m_rs1 <= (m_src1 == 0) ? m_rs1 : cur(m_src1);
                m_rs2 <= (m_src2 == 0) ? m_rs2 : cur(m_src2);
            end else begin
                m_valid <= 1'b0;
            end
            if (wb_en && wb_addr != 0) m_regs[wb_addr] <= wb_data;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  {63'd0, in_ready},  {63'd0, (!m_valid || out_ready)});
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
            chk("out_rs1",   64'(out_rs1),       64'(m_rs1));
            chk("out_rs2",   64'(out_rs2),       64'(m_rs2));
            chk("out_rd",    64'(out_rd_addr),   64'(m_rd));
            chk("out_ctrl",  64'(out_control),   64'(m_ctrl));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input int rs1, input int rs2, input int rd, input int ctl,
                        input bit we, input int wa, input logic [W-1:0] wd, input bit ordy);
        @(negedge clk);
        #1;
        in_valid = v;
        in_rs1_addr = ADDR_W'(rs1);
        in_rs2_addr = ADDR_W'(rs2);
        in_rd_addr = ADDR_W'(rd);
        in_control = 4'(ctl);
        wb_en = we;
        wb_addr = ADDR_W'(wa);
        wb_data = wd;
        out_ready = ordy;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Write r5, then read it back through the array.
        step(0, 0, 0, 0, 0, 1, 5, W'(64'hDEADBEEF), 1);
        step(1, 5, 0, 1, 2, 0, 0, '0, 1);
        settle();
        $display("[TB] txn write/read r5: rs1=0x%0h rs2=0x%0h", out_rs1, out_rs2);
        chk("wr_rd_rs1", 64'(out_rs1), 64'(W'(64'hDEADBEEF)));
        chk("wr_rd_rs2", 64'(out_rs2), 64'd0);

        // Same-cycle forward into both operands.
        step(1, 7, 7, 2, 1, 1, 7, W'(32'h1234), 1);
        settle();
        $display("[TB] txn forward r7: rs1=0x%0h rs2=0x%0h", out_rs1, out_rs2);
        chk("fwd_rs1", 64'(out_rs1), 64'h1234);
        chk("fwd_rs2", 64'(out_rs2), 64'h1234);

        // Writes to r0 are discarded, even when forwarding would apply.
        step(1, 0, 0, 3, 3, 1, 0, W'(32'hFFFF), 1);
        settle();
        chk("r0_fwd", 64'(out_rs1), 64'd0);
        step(1, 0, 7, 3, 3, 0, 0, '0, 1);
        settle();
        $display("[TB] txn r0 after write: rs1=0x%0h rs2=0x%0h", out_rs1, out_rs2);
        chk("r0_arr", 64'(out_rs1), 64'd0);
        chk("r7_arr", 64'(out_rs2), 64'h1234);

        // Backpressure: held instruction with rs2=3 sees a write to r3.
        step(1, 5, 3, 9, 4, 0, 0, '0, 1);
        settle();
        step(1, 1, 1, 11, 6, 1, 3, W'(32'h55), 0);
        settle();
        $display("[TB] txn stall refresh: rs1=0x%0h rs2=0x%0h rd=%0d ctl=%0d",
                 out_rs1, out_rs2, out_rd_addr, out_control);
        chk("stall_rs2", 64'(out_rs2), 64'h55);
        chk("stall_rs1", 64'(out_rs1), 64'(W'(64'hDEADBEEF)));
        chk("stall_rd", 64'(out_rd_addr), 64'd9);
        chk("stall_ctl", 64'(out_control), 64'd4);
        chk("stall_ready", {63'd0, in_ready}, 64'd0);
        step(0, 0, 0, 0, 0, 1, 5, W'(32'h77), 0);
        settle();
        chk("stall_rs1_ref", 64'(out_rs1), 64'h77);

        // Drain with nothing new: valid drops, data holds.
        step(0, 0, 0, 0, 0, 0, 0, '0, 1);
        settle();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);
        chk("drain_hold", 64'(out_rd_addr), 64'd9);

        // Streaming: 8 back-to-back instructions, overlapping drain and accept.
        for (int i = 0; i < 8; i++) begin
            step(1, i + 1, 8 - i, 16 + i, 15 - i, 0, 0, '0, 1);
            settle();
            $display("[TB] txn stream %0d: valid=%0d rd=%0d ctl=%0d",
                     i, out_valid, out_rd_addr, out_control);
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_rd", 64'(out_rd_addr), 64'(16 + i));
            chk("stream_ctl", 64'(out_control), 64'(15 - i));
        end
        step(0, 0, 0, 0, 0, 0, 0, '0, 1);
        settle();
        chk("stream_end", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset mid-transfer clears everything immediately.
        step(1, 5, 7, 12, 5, 0, 0, '0, 0);
        settle();
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        $display("[TB] txn async reset: valid=%0d rs1=0x%0h ready=%0d", out_valid, out_rs1, in_ready);
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_rs1", 64'(out_rs1), 64'd0);
        chk("arst_rs2", 64'(out_rs2), 64'd0);
        chk("arst_rd", 64'(out_rd_addr), 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        step(1, 5, 7, 1, 1, 0, 0, '0, 1);
        settle();
        $display("[TB] txn read after reset: rs1=0x%0h rs2=0x%0h", out_rs1, out_rs2);
        chk("post_rst_r5", 64'(out_rs1), 64'd0);
        chk("post_rst_r7", 64'(out_rs2), 64'd0);

        step(0, 0, 0, 0, 0, 0, 0, '0, 1);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
